// File: rtl/conv_buf_manager_pkg.sv
// Shared controller parameter header: array geometry, widths and buffer latency
// used by both the buffer manager and the PE array.
package conv_buf_manager_pkg;

  localparam int CBM_K            = 3;
  localparam int CBM_TOUT         = 16;
  localparam int CBM_W_SIZE       = 10;
  localparam int CBM_W_CHANNEL    = 10;
  localparam int CBM_IFM_DW       = 32;
  localparam int CBM_FILTER_DW    = 72;
  localparam int CBM_IFM_BUF_CNT  = 4;
  localparam int CBM_IFM_DEPTH    = 4096;
  localparam int CBM_FILTER_DEPTH = 1024;
  localparam int CBM_DATA_DELAY   = 2;

  // Width of an index selecting one of n items, never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bm_dpram.sv
// Simple 1R1W RAM with registered read; a same-address write and read in one
// cycle returns the previous contents. Contents are never reset.
module bm_dpram #(
  parameter int DW    = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/conv_buf_manager.sv
// Convolution buffer manager: banked IFM row buffers behind a lane crossbar with
// lowest-lane-wins arbitration, plus per-lane filter RAMs, all at a fixed latency.
module conv_buf_manager
  import conv_buf_manager_pkg::*;
#(
  parameter int K             = CBM_K,
  parameter int Tout          = CBM_TOUT,
  parameter int W_SIZE        = CBM_W_SIZE,
  parameter int W_CHANNEL     = CBM_W_CHANNEL,
  parameter int IFM_DW        = CBM_IFM_DW,
  parameter int FILTER_DW     = CBM_FILTER_DW,
  parameter int IFM_BUF_CNT   = CBM_IFM_BUF_CNT,
  parameter int IFM_DEPTH     = CBM_IFM_DEPTH,
  parameter int FILTER_DEPTH  = CBM_FILTER_DEPTH,
  parameter int BM_DATA_DELAY = CBM_DATA_DELAY
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [W_CHANNEL-1:0]             cfg_chn_tiles,
  input  logic [K-1:0]                     i_ifm_req_vld,
  input  logic [K-1:0][W_SIZE-1:0]         i_ifm_req_row,
  input  logic [K-1:0][W_SIZE-1:0]         i_ifm_req_col,
  input  logic [K-1:0][W_SIZE-1:0]         i_ifm_req_chn,
  output logic [K-1:0][IFM_DW-1:0]         o_ifm_data,
  output logic [K-1:0]                     o_ifm_data_vld,
  input  logic                             i_filter_req_vld,
  input  logic [W_CHANNEL-1:0]             i_filter_req_inchn,
  output logic [Tout-1:0][FILTER_DW-1:0]   o_filter_data,
  input  logic                             i_ifm_wr_vld,
  input  logic [W_SIZE-1:0]                i_ifm_wr_row,
  input  logic [W_SIZE-1:0]                i_ifm_wr_col,
  input  logic [W_SIZE-1:0]                i_ifm_wr_chn,
  input  logic [IFM_DW-1:0]                i_ifm_wr_data,
  input  logic                             i_flt_wr_vld,
  input  logic [$clog2(Tout)-1:0]          i_flt_wr_lane,
  input  logic [W_CHANNEL-1:0]             i_flt_wr_inchn,
  input  logic [FILTER_DW-1:0]             i_flt_wr_data,
  output logic                             o_conflict
);

  localparam int AW   = $clog2(IFM_DEPTH);
  localparam int FAW  = $clog2(FILTER_DEPTH);
  localparam int BW   = sel_width(IFM_BUF_CNT);
  localparam int LW   = $clog2(Tout);
  localparam int PW   = W_SIZE + W_CHANNEL + 1;
  localparam int PIPE = BM_DATA_DELAY - 1;

  function automatic logic [BW-1:0] bank_of(input logic [W_SIZE-1:0] row);
    return BW'(row % W_SIZE'(IFM_BUF_CNT));
  endfunction

  function automatic logic [AW-1:0] word_addr(input logic [W_SIZE-1:0] col,
                                              input logic [W_SIZE-1:0] chn,
                                              input logic [W_CHANNEL-1:0] tiles);
    logic [PW-1:0] full;
    full = PW'(col) * PW'(tiles) + PW'(chn);
    return AW'(full);
  endfunction

  logic [K-1:0][AW-1:0]               w_req_addr;
  logic [K-1:0][BW-1:0]               w_req_bank;
  logic [K-1:0]                       w_grant;
  logic                               w_conflict;
  logic [IFM_BUF_CNT-1:0]             w_bank_busy;
  logic [IFM_BUF_CNT-1:0][AW-1:0]     w_bank_raddr;
  logic [IFM_BUF_CNT-1:0][IFM_DW-1:0] w_bank_rdata;
  logic [AW-1:0]                      w_wr_addr;
  logic [BW-1:0]                      w_wr_bank;
  logic [Tout-1:0][FILTER_DW-1:0]     w_flt_rdata;
  logic [K-1:0][IFM_DW-1:0]           w_ifm_mux;

  logic [K-1:0]                       r_s1_grant;
  logic [K-1:0][BW-1:0]               r_s1_bank;
  logic                               r_s1_conflict;

  logic [K-1:0][IFM_DW-1:0]           r_ifm_data_pipe [PIPE];
  logic [K-1:0]                       r_ifm_vld_pipe  [PIPE];
  logic                               r_conflict_pipe [PIPE];
  logic                               r_flt_req_pipe  [PIPE];
  logic [Tout-1:0][FILTER_DW-1:0]     r_flt_data_pipe [PIPE];

  always_comb begin
    for (int k = 0; k < K; k++) begin
      w_req_bank[k] = bank_of(i_ifm_req_row[k]);
      w_req_addr[k] = word_addr(i_ifm_req_col[k], i_ifm_req_chn[k], cfg_chn_tiles);
    end
  end

  // Each bank serves the lowest-index valid lane that selects it; later lanes lose.
  always_comb begin
    w_grant      = '0;
    w_conflict   = 1'b0;
    w_bank_busy  = '0;
    w_bank_raddr = '0;
    for (int k = 0; k < K; k++) begin
      if (i_ifm_req_vld[k]) begin
        if (w_bank_busy[w_req_bank[k]]) begin
          w_conflict = 1'b1;
        end else begin
          w_bank_busy[w_req_bank[k]]  = 1'b1;
          w_bank_raddr[w_req_bank[k]] = w_req_addr[k];
          w_grant[k]                  = 1'b1;
        end
      end
    end
  end

  assign w_wr_bank = bank_of(i_ifm_wr_row);
  assign w_wr_addr = word_addr(i_ifm_wr_col, i_ifm_wr_chn, cfg_chn_tiles);

  for (genvar b = 0; b < IFM_BUF_CNT; b++) begin : g_ifm_bank
    bm_dpram #(
      .DW    (IFM_DW),
      .DEPTH (IFM_DEPTH)
    ) u_ifm_bank (
      .clk     (clk),
      .i_we    (i_ifm_wr_vld && (w_wr_bank == BW'(b))),
      .i_waddr (w_wr_addr),
      .i_wdata (i_ifm_wr_data),
      .i_raddr (w_bank_raddr[b]),
      .o_rdata (w_bank_rdata[b])
    );
  end

  for (genvar t = 0; t < Tout; t++) begin : g_flt_lane
    bm_dpram #(
      .DW    (FILTER_DW),
      .DEPTH (FILTER_DEPTH)
    ) u_flt_lane (
      .clk     (clk),
      .i_we    (i_flt_wr_vld && (i_flt_wr_lane == LW'(t))),
      .i_waddr (FAW'(i_flt_wr_inchn)),
      .i_wdata (i_flt_wr_data),
      .i_raddr (FAW'(i_filter_req_inchn)),
      .o_rdata (w_flt_rdata[t])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_grant    <= '0;
      r_s1_bank     <= '0;
      r_s1_conflict <= 1'b0;
    end else begin
      r_s1_grant    <= w_grant;
      r_s1_bank     <= w_req_bank;
      r_s1_conflict <= w_conflict;
    end
  end

  // Bank index travels with the read so the RAM output can be steered back per lane.
  always_comb begin
    w_ifm_mux = '0;
    for (int k = 0; k < K; k++) begin
      if (r_s1_grant[k]) begin
        w_ifm_mux[k] = w_bank_rdata[r_s1_bank[k]];
      end
    end
  end

  // Filter stages load only behind a valid request, so the last stage holds its value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE; i++) begin
        r_ifm_data_pipe[i] <= '0;
        r_ifm_vld_pipe[i]  <= '0;
        r_conflict_pipe[i] <= 1'b0;
        r_flt_req_pipe[i]  <= 1'b0;
        r_flt_data_pipe[i] <= '0;
      end
    end else begin
      r_ifm_data_pipe[0] <= w_ifm_mux;
      r_ifm_vld_pipe[0]  <= r_s1_grant;
      r_conflict_pipe[0] <= r_s1_conflict;
      r_flt_req_pipe[0]  <= i_filter_req_vld;
      if (r_flt_req_pipe[0]) begin
        r_flt_data_pipe[0] <= w_flt_rdata;
      end
      for (int i = 1; i < PIPE; i++) begin
        r_ifm_data_pipe[i] <= r_ifm_data_pipe[i-1];
        r_ifm_vld_pipe[i]  <= r_ifm_vld_pipe[i-1];
        r_conflict_pipe[i] <= r_conflict_pipe[i-1];
        r_flt_req_pipe[i]  <= r_flt_req_pipe[i-1];
        if (r_flt_req_pipe[i]) begin
          r_flt_data_pipe[i] <= r_flt_data_pipe[i-1];
        end
      end
    end
  end

  assign o_ifm_data     = r_ifm_data_pipe[PIPE-1];
  assign o_ifm_data_vld = r_ifm_vld_pipe[PIPE-1];
  assign o_conflict     = r_conflict_pipe[PIPE-1];
  assign o_filter_data  = r_flt_data_pipe[PIPE-1];

endmodule

// File: tb/tb_conv_buf_manager.sv
// Bench for conv_buf_manager: directed scenarios plus random traffic, every cycle
// compared against a memory-array model scheduled through a latency queue.
module tb_conv_buf_manager;

  localparam int K      = 3;
  localparam int TOUT   = 16;
  localparam int WS     = 10;
  localparam int WC     = 10;
  localparam int IDW    = 32;
  localparam int FDW    = 72;
  localparam int NB     = 4;
  localparam int IDEPTH = 4096;
  localparam int FDEPTH = 1024;
  localparam int D      = 2;
  localparam int TILES  = 4;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [WC-1:0]             cfg_chn_tiles;
  logic [K-1:0]              i_ifm_req_vld;
  logic [K-1:0][WS-1:0]      i_ifm_req_row;
  logic [K-1:0][WS-1:0]      i_ifm_req_col;
  logic [K-1:0][WS-1:0]      i_ifm_req_chn;
  logic [K-1:0][IDW-1:0]     o_ifm_data;
  logic [K-1:0]              o_ifm_data_vld;
  logic                      i_filter_req_vld;
  logic [WC-1:0]             i_filter_req_inchn;
  logic [TOUT-1:0][FDW-1:0]  o_filter_data;
  logic                      i_ifm_wr_vld;
  logic [WS-1:0]             i_ifm_wr_row;
  logic [WS-1:0]             i_ifm_wr_col;
  logic [WS-1:0]             i_ifm_wr_chn;
  logic [IDW-1:0]            i_ifm_wr_data;
  logic                      i_flt_wr_vld;
  logic [3:0]                i_flt_wr_lane;
  logic [WC-1:0]             i_flt_wr_inchn;
  logic [FDW-1:0]            i_flt_wr_data;
  logic                      o_conflict;

  always #5 clk = ~clk;

  conv_buf_manager dut (
    .clk                (clk),
    .rst                (rst),
    .cfg_chn_tiles      (cfg_chn_tiles),
    .i_ifm_req_vld      (i_ifm_req_vld),
    .i_ifm_req_row      (i_ifm_req_row),
    .i_ifm_req_col      (i_ifm_req_col),
    .i_ifm_req_chn      (i_ifm_req_chn),
    .o_ifm_data         (o_ifm_data),
    .o_ifm_data_vld     (o_ifm_data_vld),
    .i_filter_req_vld   (i_filter_req_vld),
    .i_filter_req_inchn (i_filter_req_inchn),
    .o_filter_data      (o_filter_data),
    .i_ifm_wr_vld       (i_ifm_wr_vld),
    .i_ifm_wr_row       (i_ifm_wr_row),
    .i_ifm_wr_col       (i_ifm_wr_col),
    .i_ifm_wr_chn       (i_ifm_wr_chn),
    .i_ifm_wr_data      (i_ifm_wr_data),
    .i_flt_wr_vld       (i_flt_wr_vld),
    .i_flt_wr_lane      (i_flt_wr_lane),
    .i_flt_wr_inchn     (i_flt_wr_inchn),
    .i_flt_wr_data      (i_flt_wr_data),
    .o_conflict         (o_conflict)
  );

  typedef struct {
    logic                 rst;
    logic [K-1:0]         vld;
    logic [K-1:0][WS-1:0] row;
    logic [K-1:0][WS-1:0] col;
    logic [K-1:0][WS-1:0] chn;
    logic                 freq;
    logic [WC-1:0]        finchn;
    logic                 iwr;
    logic [WS-1:0]        iwrow;
    logic [WS-1:0]        iwcol;
    logic [WS-1:0]        iwchn;
    logic [IDW-1:0]       iwdata;
    logic                 fwr;
    logic [3:0]           fwlane;
    logic [WC-1:0]        fwinchn;
    logic [FDW-1:0]       fwdata;
  } stim_t;

  typedef struct {
    logic [K-1:0]             vld;
    logic [K-1:0][IDW-1:0]    data;
    logic                     conf;
    logic [TOUT-1:0][FDW-1:0] flt;
  } exp_t;

  logic [IDW-1:0]           m_ifm [NB][IDEPTH];
  logic [FDW-1:0]           m_flt [TOUT][FDEPTH];
  logic [TOUT-1:0][FDW-1:0] fltLast;
  exp_t                     expQ[$];
  int                       checks = 0;
  int                       errors = 0;
  int                       cycle  = 0;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got %h expected %h", tag, cycle, obs, expv);
    end
  endtask

  function automatic exp_t zeroExp();
    exp_t e;
    e.vld  = '0;
    e.data = '0;
    e.conf = 1'b0;
    e.flt  = '0;
    return e;
  endfunction

  function automatic stim_t idleStim();
    stim_t s;
    s.rst = 1'b0; s.vld = '0; s.row = '0; s.col = '0; s.chn = '0;
    s.freq = 1'b0; s.finchn = '0;
    s.iwr = 1'b0; s.iwrow = '0; s.iwcol = '0; s.iwchn = '0; s.iwdata = '0;
    s.fwr = 1'b0; s.fwlane = '0; s.fwinchn = '0; s.fwdata = '0;
    return s;
  endfunction

  function automatic int wordAddr(input int col, input int chn);
    return (col * TILES + chn) % IDEPTH;
  endfunction

  // One cycle: check what the DUT shows after this edge, then drive the next inputs
  // and queue the response the model predicts for them D cycles later.
  task automatic applyStimulus(input stim_t s);
    exp_t e;
    exp_t n;
    bit [NB-1:0] busy;
    int b;
    @(posedge clk);
    #1;
    cycle++;
    e = expQ.pop_front();
    checkOutput("ifm_vld", 128'(o_ifm_data_vld), 128'(e.vld));
    for (int k = 0; k < K; k++)
      checkOutput($sformatf("ifm_data%0d", k), 128'(o_ifm_data[k]), 128'(e.data[k]));
    checkOutput("conflict", 128'(o_conflict), 128'(e.conf));
    for (int t = 0; t < TOUT; t++)
      checkOutput($sformatf("flt_data%0d", t), 128'(o_filter_data[t]), 128'(e.flt[t]));

    rst = s.rst; i_ifm_req_vld = s.vld;
    i_ifm_req_row = s.row; i_ifm_req_col = s.col; i_ifm_req_chn = s.chn;
    i_filter_req_vld = s.freq; i_filter_req_inchn = s.finchn;
    i_ifm_wr_vld = s.iwr; i_ifm_wr_row = s.iwrow; i_ifm_wr_col = s.iwcol;
    i_ifm_wr_chn = s.iwchn; i_ifm_wr_data = s.iwdata;
    i_flt_wr_vld = s.fwr; i_flt_wr_lane = s.fwlane;
    i_flt_wr_inchn = s.fwinchn; i_flt_wr_data = s.fwdata;

    if (s.rst) begin
      expQ.delete();
      for (int i = 0; i < D; i++) expQ.push_back(zeroExp());
      fltLast = '0;
    end else begin
      n = zeroExp();
      busy = '0;
      for (int k = 0; k < K; k++) begin
        if (s.vld[k]) begin
          b = int'(s.row[k]) % NB;
          if (busy[b]) n.conf = 1'b1;
          else begin
            busy[b]   = 1'b1;
            n.vld[k]  = 1'b1;
            n.data[k] = m_ifm[b][wordAddr(int'(s.col[k]), int'(s.chn[k]))];
          end
        end
      end
      if (s.freq)
        for (int t = 0; t < TOUT; t++) fltLast[t] = m_flt[t][int'(s.finchn) % FDEPTH];
      n.flt = fltLast;
      expQ.push_back(n);
      if (s.iwr) m_ifm[int'(s.iwrow) % NB][wordAddr(int'(s.iwcol), int'(s.iwchn))] = s.iwdata;
      if (s.fwr) m_flt[s.fwlane][int'(s.fwinchn) % FDEPTH] = s.fwdata;
    end
  endtask

  initial begin
    stim_t s;
    logic [FDW-1:0] fdata;

    cfg_chn_tiles = WC'(TILES);
    rst = 1'b1; i_ifm_req_vld = '0; i_ifm_req_row = '0; i_ifm_req_col = '0; i_ifm_req_chn = '0;
    i_filter_req_vld = 1'b0; i_filter_req_inchn = '0;
    i_ifm_wr_vld = 1'b0; i_ifm_wr_row = '0; i_ifm_wr_col = '0; i_ifm_wr_chn = '0; i_ifm_wr_data = '0;
    i_flt_wr_vld = 1'b0; i_flt_wr_lane = '0; i_flt_wr_inchn = '0; i_flt_wr_data = '0;
    fltLast = '0;
    for (int i = 0; i < D; i++) expQ.push_back(zeroExp());

    s = idleStim(); s.rst = 1'b1;
    applyStimulus(s);
    applyStimulus(s);

    // Fill every address the traffic below can read.
    for (int r = 0; r < NB; r++)
      for (int c = 0; c < 64; c++)
        for (int ch = 0; ch < TILES; ch++) begin
          s = idleStim(); s.iwr = 1'b1;
          s.iwrow = WS'(r); s.iwcol = WS'(c); s.iwchn = WS'(ch); s.iwdata = $urandom;
          applyStimulus(s);
        end
    for (int t = 0; t < TOUT; t++)
      for (int a = 0; a < 16; a++) begin
        s = idleStim(); s.fwr = 1'b1; s.fwlane = 4'(t); s.fwinchn = WC'(a);
        fdata = {8'($urandom), $urandom, $urandom};
        s.fwdata = fdata;
        applyStimulus(s);
      end

    for (int r = 0; r < NB; r++) begin
      s = idleStim(); s.iwr = 1'b1;
      s.iwrow = WS'(r); s.iwcol = 10'd5; s.iwchn = 10'd1; s.iwdata = 32'hA0 + 32'(r);
      applyStimulus(s);
    end

    // Three lanes, three different banks.
    s = idleStim(); s.vld = 3'b111;
    for (int k = 0; k < K; k++) begin
      s.row[k] = WS'(k + 1); s.col[k] = 10'd5; s.chn[k] = 10'd1;
    end
    applyStimulus(s);
    applyStimulus(idleStim());
    applyStimulus(idleStim());
    checkOutput("dir_all_lanes_vld", 128'(o_ifm_data_vld), 128'(3'b111));
    checkOutput("dir_lane2_data", 128'(o_ifm_data[2]), 128'(32'hA3));

    // Only the middle lane requests; outer lanes pad with zero.
    s.vld = 3'b010;
    applyStimulus(s);
    applyStimulus(idleStim());
    applyStimulus(idleStim());
    checkOutput("dir_pad_vld", 128'(o_ifm_data_vld), 128'(3'b010));
    checkOutput("dir_pad_lane1", 128'(o_ifm_data[1]), 128'(32'hA2));
    checkOutput("dir_pad_lane0", 128'(o_ifm_data[0]), 128'(0));

    // Rows 0 and 4 share bank 0.
    s = idleStim(); s.vld = 3'b011;
    s.row[0] = 10'd0; s.row[1] = 10'd4;
    s.col[0] = 10'd5; s.col[1] = 10'd5; s.chn[0] = 10'd1; s.chn[1] = 10'd1;
    applyStimulus(s);
    applyStimulus(idleStim());
    applyStimulus(idleStim());
    checkOutput("dir_conflict", 128'(o_conflict), 128'(1));
    checkOutput("dir_conflict_lane0", 128'(o_ifm_data[0]), 128'(32'hA0));
    checkOutput("dir_conflict_lane1", 128'(o_ifm_data[1]), 128'(0));
    applyStimulus(idleStim());
    checkOutput("dir_conflict_pulse", 128'(o_conflict), 128'(0));

    for (int t = 0; t < TOUT; t++) begin
      s = idleStim(); s.fwr = 1'b1; s.fwlane = 4'(t); s.fwinchn = 10'd7; s.fwdata = 72'(t + 1);
      applyStimulus(s);
    end
    s = idleStim(); s.freq = 1'b1; s.finchn = 10'd7;
    applyStimulus(s);
    applyStimulus(idleStim());
    applyStimulus(idleStim());
    checkOutput("dir_flt_lane15", 128'(o_filter_data[15]), 128'(72'd16));
    for (int i = 0; i < 3; i++) applyStimulus(idleStim());
    checkOutput("dir_flt_hold_lane0", 128'(o_filter_data[0]), 128'(72'd1));

    // Streaming columns, with a write landing on lane 0's read address mid-stream.
    for (int c = 0; c < 64; c++) begin
      s = idleStim(); s.vld = 3'b111;
      for (int k = 0; k < K; k++) begin
        s.row[k] = WS'(k); s.col[k] = WS'(c); s.chn[k] = 10'd0;
      end
      if (c == 10) begin
        s.iwr = 1'b1; s.iwrow = 10'd0; s.iwcol = 10'd10; s.iwchn = 10'd0; s.iwdata = 32'hDEADBEEF;
      end
      applyStimulus(s);
    end
    s = idleStim(); s.vld = 3'b001; s.col[0] = 10'd10;
    applyStimulus(s);
    applyStimulus(idleStim());
    applyStimulus(idleStim());
    checkOutput("dir_write_visible", 128'(o_ifm_data[0]), 128'(32'hDEADBEEF));

    // Reset with two requests in flight.
    s = idleStim(); s.vld = 3'b111;
    for (int k = 0; k < K; k++) begin
      s.row[k] = WS'(k); s.col[k] = 10'd3; s.chn[k] = 10'd2;
    end
    applyStimulus(s);
    s.col = {10'd4, 10'd4, 10'd4};
    applyStimulus(s);
    s = idleStim(); s.rst = 1'b1;
    applyStimulus(s);
    for (int i = 0; i < 4; i++) applyStimulus(idleStim());
    checkOutput("dir_rst_vld", 128'(o_ifm_data_vld), 128'(0));
    checkOutput("dir_rst_flt", 128'(o_filter_data[3]), 128'(0));

    for (int i = 0; i < 1500; i++) begin
      s = idleStim();
      if ($urandom_range(0, 199) == 0) s.rst = 1'b1;
      else begin
        s.vld = 3'($urandom_range(0, 7));
        for (int k = 0; k < K; k++) begin
          s.row[k] = WS'($urandom_range(0, 15));
          s.col[k] = WS'($urandom_range(0, 63));
          s.chn[k] = WS'($urandom_range(0, TILES - 1));
        end
        s.freq   = 1'($urandom_range(0, 1));
        s.finchn = WC'($urandom_range(0, 15));
        s.iwr    = 1'($urandom_range(0, 1));
        s.iwdata = $urandom;
        if (s.vld[0] && $urandom_range(0, 3) == 0) begin
          s.iwrow = s.row[0]; s.iwcol = s.col[0]; s.iwchn = s.chn[0];
        end else begin
          s.iwrow = WS'($urandom_range(0, 15));
          s.iwcol = WS'($urandom_range(0, 63));
          s.iwchn = WS'($urandom_range(0, TILES - 1));
        end
        s.fwr     = ($urandom_range(0, 9) < 3);
        s.fwlane  = 4'($urandom_range(0, TOUT - 1));
        s.fwinchn = ($urandom_range(0, 1) == 1) ? s.finchn : WC'($urandom_range(0, 15));
        fdata = {8'($urandom), $urandom, $urandom};
        s.fwdata = fdata;
      end
      applyStimulus(s);
    end

    for (int i = 0; i < D + 1; i++) applyStimulus(idleStim());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_buf_manager.md
CONV_BUF_MANAGER -- requirements
Module: conv_buf_manager

Interface
REQ-001 SHALL have parameter K, default 3, kernel size and number of IFM request lanes.
REQ-002 SHALL have parameter Tout, default 16, number of filter output lanes.
REQ-003 SHALL have parameters W_SIZE 10, W_CHANNEL 10, IFM_DW 32, FILTER_DW 72, the row/col, channel and data widths.
REQ-004 SHALL have parameter IFM_BUF_CNT, default 4, number of IFM row banks (power of two); IFM_DEPTH 4096 words per bank; FILTER_DEPTH 1024 words per lane.
REQ-005 SHALL have parameter BM_DATA_DELAY, default 2, fixed request-to-data latency in cycles (minimum 2).
REQ-006 Ports, in order (name, direction, width, meaning):
  clk  in  1  the only clock, rising edge.
  rst  in  1  synchronous, active-high reset.
  cfg_chn_tiles  in  W_CHANNEL  channel tiles per column; held stable while requests are active.
  i_ifm_req_vld  in  K  per-lane read request.
  i_ifm_req_row / _col / _chn  in  K x W_SIZE each  per-lane address (chn uses W_SIZE, matching the requester).
  o_ifm_data  out  K x IFM_DW  per-lane read data.
  o_ifm_data_vld  out  K  per-lane data-valid strobe.
  i_filter_req_vld  in  1  filter read request.
  i_filter_req_inchn  in  W_CHANNEL  filter word address.
  o_filter_data  out  Tout x FILTER_DW  filter words.
  i_ifm_wr_vld  in  1;  i_ifm_wr_row, i_ifm_wr_col, i_ifm_wr_chn  in  W_SIZE each;  i_ifm_wr_data  in  IFM_DW  IFM fill port.
  i_flt_wr_vld  in  1;  i_flt_wr_lane  in  clog2(Tout);  i_flt_wr_inchn  in  W_CHANNEL;  i_flt_wr_data  in  FILTER_DW  filter fill port.
  o_conflict  out  1  bank-conflict pulse.

Function
REQ-007 Bank select SHALL be row mod IFM_BUF_CNT; word address SHALL be col*cfg_chn_tiles + chn, truncated to clog2(IFM_DEPTH) bits.
REQ-008 A request valid in cycle n SHALL produce o_ifm_data[k] and o_ifm_data_vld[k]=1 in cycle n+BM_DATA_DELAY, fully pipelined: one new request per lane per cycle, no stall.
REQ-009 When i_ifm_req_vld[k]=0 in cycle n, o_ifm_data[k] SHALL be all zeros in cycle n+BM_DATA_DELAY (zero padding) and o_ifm_data_vld[k]=0.
REQ-010 Lanes SHALL be routed through a K x IFM_BUF_CNT crossbar; the selected bank index SHALL be pipelined alongside the read for the output mux.
REQ-011 If two or more valid lanes select the same bank in one cycle: the lowest-index lane is served, the other lanes return zero with vld=0, and o_conflict=1 in cycle n+BM_DATA_DELAY.
REQ-012 A filter request valid in cycle n SHALL update all Tout words of o_filter_data in cycle n+BM_DATA_DELAY; with no request, o_filter_data SHALL hold its last value.
REQ-013 Each bank and each filter lane SHALL be a 1R1W RAM. A write and a read to the same address in the same cycle SHALL return the old data. A write is visible to reads issued one or more cycles later.
REQ-014 IFM and filter writes SHALL always be accepted in one cycle; there is no write back-pressure.
REQ-015 RAM contents SHALL NOT be cleared by rst.

Reset
REQ-016 On rst=1 at a clock edge: o_ifm_data=0, o_ifm_data_vld=0, o_filter_data=0, o_conflict=0, and all latency-pipe valid bits cleared.
REQ-017 Requests in flight when rst is asserted SHALL be dropped. No output valid SHALL appear from them after rst deasserts.
REQ-018 A request presented in the first cycle with rst=0 SHALL be served normally.

Structure
REQ-019 K, Tout, the widths, IFM_BUF_CNT and BM_DATA_DELAY SHALL come from the shared controller parameter header, the same values the PE uses.
REQ-020 A single sub-module, bm_dpram (parameterised width/depth, 1R1W, registered read), SHALL be instantiated IFM_BUF_CNT + Tout times.

Verification
REQ-021 Write IFM rows 0-3, col 5, chn 1 (cfg_chn_tiles=4) with data 0xA0..0xA3; request lanes rows 1,2,3 in cycle 10 -> cycle 12 data = 0xA1,0xA2,0xA3, vld=3'b111.
REQ-022 Request with i_ifm_req_vld=3'b010 (first-row padding) -> lanes 0 and 2 return 0, vld=3'b010, lane 1 correct.
REQ-023 Lanes request rows 0 and 4 (same bank 0) -> lane 0 served, lane with row 4 returns 0, o_conflict=1 for one cycle.
REQ-024 Write filter inchn 7 on all lanes with 72'h1..16; request inchn 7, then idle 5 cycles -> data appears after 2 cycles and holds for all 5 idle cycles.
REQ-025 Back-to-back requests for 64 consecutive cols -> 64 consecutive valid outputs, no bubble; a same-cycle write to the address being read returns the old value.
REQ-026 Assert rst for 1 cycle with 2 requests in flight -> no vld appears after rst deasserts; all outputs are 0.
